flicker_pwm: RTL and testbench

LED drive stage of the candle-flicker design. Takes 8-bit intensity samples from the upstream flicker-intensity generator over a valid/ready handshake and holds one sample in a pending buffer. It applies each sample at the next PWM period boundary, slew-limited, and produces the PWM waveform on the LED output pin (io_out[0] at top level).

---
 rtl/flicker_pkg.sv | 11 +
 rtl/flicker_pwm_if.sv | 11 +
 rtl/flicker_tick_gen.sv | 27 ++
 rtl/flicker_pwm.sv | 128 ++++++++++++
 tb/tb_flicker_pwm.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/flicker_pkg.sv
// Shared constants and types for the candle-flicker LED drive stage.
package flicker_pkg;

   localparam int DUTY_W     = 8;
   localparam int PRESCALE_W = 4;
   localparam int SLEW_MAX   = 16;
   localparam int DUTY_MAX   = (1 << DUTY_W) - 1;

   typedef logic [DUTY_W-1:0] duty_t;

endpackage

// File: rtl/flicker_pwm_if.sv
// Intensity-sample handshake between the flicker generator and the PWM stage.
interface flicker_pwm_if #(
   parameter int DUTY_W = flicker_pkg::DUTY_W
);
   logic [DUTY_W-1:0] level_data;
   logic              level_valid;
   logic              level_ready;

   modport master (output level_data, output level_valid, input level_ready);
   modport slave  (input level_data, input level_valid, output level_ready);
endinterface

// File: rtl/flicker_tick_gen.sv
// Runtime-programmable prescaler: one tick every i_prescale+1 clock cycles.
module flicker_tick_gen #(
   parameter int PRESCALE_W = flicker_pkg::PRESCALE_W
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [PRESCALE_W-1:0] i_prescale,
   output logic                  o_tick
);

   logic [PRESCALE_W-1:0] r_presc_cnt;

   // >= lets a lowered prescale take effect at once instead of waiting for a wrap
   assign o_tick = (r_presc_cnt >= i_prescale);

   // prescale counter, cleared on every tick
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_presc_cnt <= '0;
      end else if (o_tick) begin
         r_presc_cnt <= '0;
      end else begin
         r_presc_cnt <= r_presc_cnt + PRESCALE_W'(1);
      end
   end

endmodule

// File: rtl/flicker_pwm.sv
// LED PWM drive: buffers one intensity sample, applies it slew-limited at each
// PWM period boundary and drives the registered PWM pin.
module flicker_pwm #(
   parameter int DUTY_W     = flicker_pkg::DUTY_W,
   parameter int PRESCALE_W = flicker_pkg::PRESCALE_W,
   parameter int SLEW_MAX   = flicker_pkg::SLEW_MAX
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [PRESCALE_W-1:0] i_prescale,
   flicker_pwm_if.slave          lvl,
   output logic                  o_led,
   output logic                  o_period_start
);

   localparam logic [DUTY_W-1:0] CNT_MAX = '1;
   localparam logic [DUTY_W:0]   SLEW_W1 = (DUTY_W+1)'(SLEW_MAX);
   localparam logic [DUTY_W-1:0] SLEW_D  = DUTY_W'(SLEW_MAX);

   logic              w_tick;
   logic              w_boundary;
   logic              w_accept;
   logic [DUTY_W-1:0] w_tgt_eff;
   logic [DUTY_W:0]   w_up;
   logic [DUTY_W:0]   w_dn;
   logic [DUTY_W-1:0] w_duty_next;

   logic [DUTY_W-1:0] r_pwm_cnt;
   logic [DUTY_W-1:0] r_duty;
   logic [DUTY_W-1:0] r_target;
   logic [DUTY_W-1:0] r_pend;
   logic              r_pend_full;
   logic              r_led;
   logic              r_period_start;

   flicker_tick_gen #(
      .PRESCALE_W (PRESCALE_W)
   ) u_tick_gen (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_prescale (i_prescale),
      .o_tick     (w_tick)
   );

   assign w_boundary      = w_tick & (r_pwm_cnt == CNT_MAX);
   assign lvl.level_ready = ~r_pend_full | w_boundary;
   assign w_accept        = lvl.level_valid & lvl.level_ready;

   // a pending sample overrides the old target within the same boundary
   assign w_tgt_eff = r_pend_full ? r_pend : r_target;
   assign w_up      = {1'b0, w_tgt_eff} - {1'b0, r_duty};
   assign w_dn      = {1'b0, r_duty} - {1'b0, w_tgt_eff};

   // slew-limited step toward the effective target, never passing it
   always_comb begin
      w_duty_next = r_duty;
      if (w_tgt_eff > r_duty) begin
         if (w_up > SLEW_W1) begin
            w_duty_next = r_duty + SLEW_D;
         end else begin
            w_duty_next = w_tgt_eff;
         end
      end else begin
         if (w_dn > SLEW_W1) begin
            w_duty_next = r_duty - SLEW_D;
         end else begin
            w_duty_next = w_tgt_eff;
         end
      end
   end

   // PWM period counter, wraps naturally at the top of the range
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_pwm_cnt <= '0;
      end else if (w_tick) begin
         r_pwm_cnt <= r_pwm_cnt + DUTY_W'(1);
      end else begin
         r_pwm_cnt <= r_pwm_cnt;
      end
   end

   // pending buffer; an accept on a boundary refills it right after it drains
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_pend      <= '0;
         r_pend_full <= 1'b0;
      end else if (w_accept) begin
         r_pend      <= lvl.level_data;
         r_pend_full <= 1'b1;
      end else if (w_boundary) begin
         r_pend      <= r_pend;
         r_pend_full <= 1'b0;
      end else begin
         r_pend      <= r_pend;
         r_pend_full <= r_pend_full;
      end
   end

   // target and duty only move at a period boundary
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_target <= '0;
         r_duty   <= '0;
      end else if (w_boundary) begin
         r_target <= w_tgt_eff;
         r_duty   <= w_duty_next;
      end else begin
         r_target <= r_target;
         r_duty   <= r_duty;
      end
   end

   // registered pin drivers
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_led          <= 1'b0;
         r_period_start <= 1'b0;
      end else begin
         r_led          <= (r_pwm_cnt < r_duty);
         r_period_start <= w_boundary;
      end
   end

   assign o_led          = r_led;
   assign o_period_start = r_period_start;

endmodule

// File: tb/tb_flicker_pwm.sv
// Directed bench for flicker_pwm: default-slew DUT (a) and a SLEW_MAX=255 DUT (b).
module tb_flicker_pwm;
   import flicker_pkg::*;

   logic                  clk;
   logic                  rst_n;
   logic [PRESCALE_W-1:0] prescale;
   logic                  led_a, led_b, ps_a, ps_b;

   int n_checks, n_fail, cyc;
   int p_cnt, p_cyc, hi_a, hi_b, meas_a, meas_b;

   flicker_pwm_if bus_a ();
   flicker_pwm_if bus_b ();

   flicker_pwm dut_a (
      .i_clk (clk), .i_rst (rst_n), .i_prescale (prescale),
      .lvl (bus_a), .o_led (led_a), .o_period_start (ps_a)
   );

   flicker_pwm #(.SLEW_MAX (255)) dut_b (
      .i_clk (clk), .i_rst (rst_n), .i_prescale (prescale),
      .lvl (bus_b), .o_led (led_b), .o_period_start (ps_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // high-time per PWM period, latched at each period_start
   always @(negedge clk) begin
      if (ps_a) begin
         meas_a <= hi_a + int'(led_a);
         meas_b <= hi_b + int'(led_b);
         hi_a   <= 0;
         hi_b   <= 0;
         p_cyc  <= cyc;
         p_cnt  <= p_cnt + 1;
      end else begin
         hi_a <= hi_a + int'(led_a);
         hi_b <= hi_b + int'(led_b);
      end
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_pstart(input int bound);
      int  start;
      bit  seen;
      start = p_cnt;
      seen  = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(posedge clk);
         if (p_cnt != start) seen = 1'b1;
      end
      if (!seen) check_eq("pstart_timeout", 0, 1);
   endtask

   task automatic wait_ready(input int sel);
      logic rdy;
      rdy = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         rdy = (sel == 0) ? bus_a.level_ready : bus_b.level_ready;
         if (rdy) break;
         @(negedge clk);
      end
      if (!rdy) check_eq("ready_timeout", 0, 1);
   endtask

   task automatic send(input int sel, input int v);
      @(negedge clk);
      if (sel == 0) begin
         bus_a.level_data  = duty_t'(v);
         bus_a.level_valid = 1'b1;
      end else begin
         bus_b.level_data  = duty_t'(v);
         bus_b.level_valid = 1'b1;
      end
      wait_ready(sel);
      @(posedge clk);
      #1;
      bus_a.level_valid = 1'b0;
      bus_b.level_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first, last, bad_led, bad_rdy, mism, c1;
      rst_n = 1'b0;
      prescale = '0;
      bus_a.level_valid = 1'b0; bus_a.level_data = '0;
      bus_b.level_valid = 1'b0; bus_b.level_data = '0;
      #22;
      check_eq("rst_led", int'(led_a), 0);
      check_eq("rst_pstart", int'(ps_a), 0);
      check_eq("rst_ready_a", int'(bus_a.level_ready), 1);
      check_eq("rst_ready_b", int'(bus_b.level_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: idle run, prescale 0
      first = -1; last = -1; bad_led = 0; bad_rdy = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         bad_led += int'(led_a | led_b);
         bad_rdy += int'(!(bus_a.level_ready & bus_b.level_ready));
         if (ps_a) begin
            if (first < 0) first = i;
            if (last >= 0) check_eq("t1_period", i - last, 256);
            last = i;
         end
      end
      check_eq("t1_first_pstart", first, 255);
      check_eq("t1_led_low", bad_led, 0);
      check_eq("t1_ready_high", bad_rdy, 0);

      // 2: full-slew DUT, duty 64 waveform
      send(1, 64);
      wait_pstart(3000);
      mism = 0;
      for (int k = 1; k <= 256; k++) begin
         @(negedge clk);
         if (int'(led_b) != ((k <= 64) ? 1 : 0)) mism++;
      end
      check_eq("t2_wave", mism, 0);
      @(posedge clk);
      check_eq("t2_meas", meas_b, 64);

      // 3: slew-limited ramp up to 200, then down to 10
      send(0, 200);
      wait_pstart(3000);
      for (int k = 1; k <= 14; k++) begin
         wait_pstart(3000);
         check_eq("t3_up", meas_a, (k <= 12) ? 16 * k : 200);
      end
      send(0, 10);
      wait_pstart(3000);
      for (int k = 1; k <= 13; k++) begin
         wait_pstart(3000);
         check_eq("t3_down", meas_a, (k <= 11) ? 200 - 16 * k : 10);
      end

      // 4: backpressure 30, 90, 150 with valid held
      @(negedge clk);
      bus_a.level_data = 8'd30; bus_a.level_valid = 1'b1;
      check_eq("t4_ready_30", int'(bus_a.level_ready), 1);
      @(posedge clk); #1;
      bus_a.level_data = 8'd90;
      @(negedge clk);
      check_eq("t4_stall_90", int'(bus_a.level_ready), 0);
      wait_ready(0);
      @(posedge clk); #1;
      check_eq("t4_90_at_boundary", int'(ps_a), 1);
      bus_a.level_data = 8'd150;
      @(negedge clk);
      check_eq("t4_stall_150", int'(bus_a.level_ready), 0);
      wait_ready(0);
      @(posedge clk); #1;
      check_eq("t4_150_at_boundary", int'(ps_a), 1);
      bus_a.level_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         wait_pstart(3000);
         check_eq("t4_duty", meas_a, (k < 8) ? 26 + 16 * k : 150);
      end
      @(negedge clk);
      check_eq("t4_pend_empty", int'(bus_a.level_ready), 1);

      // 5: prescale 3, then 3 -> 1 with the prescaler at 2
      @(negedge clk);
      prescale = 4'd3;
      wait_pstart(5000);
      wait_pstart(5000);
      c1 = p_cyc;
      wait_pstart(5000);
      check_eq("t5_spacing_1024", p_cyc - c1, 1024);
      c1 = p_cyc;
      @(negedge clk);
      @(negedge clk);
      prescale = 4'd1;
      wait_pstart(5000);
      check_eq("t5_switch_513", p_cyc - c1, 513);
      c1 = p_cyc;
      wait_pstart(5000);
      check_eq("t5_spacing_512", p_cyc - c1, 512);
      @(negedge clk);
      prescale = 4'd0;
      wait_pstart(5000);

      // 6: async reset mid-period with duty 128 and a sample pending
      send(1, 128);
      wait_pstart(3000);
      send(1, 200);
      repeat (30) @(posedge clk);
      #2;
      check_eq("t6_pre_led", int'(led_b), 1);
      check_eq("t6_pre_ready", int'(bus_b.level_ready), 0);
      rst_n = 1'b0;
      #1;
      check_eq("t6_rst_led", int'(led_b), 0);
      check_eq("t6_rst_ready", int'(bus_b.level_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      bad_led = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         bad_led += int'(led_a | led_b);
      end
      check_eq("t6_no_stale_apply", bad_led, 0);
      send(1, 40);
      wait_pstart(3000);
      wait_pstart(3000);
      check_eq("t6_new_sample", meas_b, 40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
